// File: rtl/microwave_countdown_timer_pkg.sv
// Shared types and BCD limits for the microwave countdown timer.
package microwave_countdown_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [3:0] SEC_UNITS_MAX = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
   localparam logic [3:0] MIN_UNITS_MAX = 4'd9;

endpackage

// File: rtl/microwave_countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit; wraps to MAX and borrows from the next digit.
module bcd_down_digit #(
   parameter logic [3:0] MAX = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   input  logic       step,
   output logic [3:0] digit,
   output logic       wrap
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         digit <= 4'd0;
      else if (load)
         digit <= (load_val > MAX) ? MAX : load_val;
      else if (dec && step)
         digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
   end

   // Borrow propagates only when this digit is asked to step and is at zero.
   assign wrap = step && (digit == 4'd0);

endmodule

// File: rtl/microwave_countdown_timer.sv
// Cook-cycle sequencer and m:ss BCD countdown driven by the 1 Hz pulse.
module microwave_countdown_timer
   import microwave_countdown_timer_pkg::*;
#(
   parameter int DONE_HOLD_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pgt_1Hz,
   input  logic       loadn,
   input  logic [3:0] data_sec_units,
   input  logic [3:0] data_sec_tens,
   input  logic [3:0] data_min_units,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       door_closed,
   output logic [3:0] sec_units,
   output logic [3:0] sec_tens,
   output logic [3:0] min_units,
   output logic       zero,
   output logic       magnetron_on,
   output logic       done_beep
);

   localparam logic [3:0] HOLD = 4'(DONE_HOLD_TICKS);

   state_t     state;
   state_t     state_n;
   logic [3:0] beep_cnt;
   logic [3:0] beep_n;
   logic       pgt_d;
   logic       tick;
   logic       load_en;
   logic       clr_en;
   logic       dec_en;
   logic       last;
   logic       su_wrap;
   logic       st_wrap;
   logic       mu_wrap;

   assign tick = pgt_1Hz && !pgt_d;
   assign zero = (sec_units == 4'd0) && (sec_tens == 4'd0)
              && (min_units == 4'd0);
   assign last = (sec_units == 4'd1) && (sec_tens == 4'd0)
              && (min_units == 4'd0);

   bcd_down_digit #(.MAX(SEC_UNITS_MAX)) u_sec_units (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_en),
      .load     (load_en),
      .load_val (data_sec_units),
      .dec      (dec_en),
      .step     (1'b1),
      .digit    (sec_units),
      .wrap     (su_wrap)
   );

   bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_en),
      .load     (load_en),
      .load_val (data_sec_tens),
      .dec      (dec_en),
      .step     (su_wrap),
      .digit    (sec_tens),
      .wrap     (st_wrap)
   );

   bcd_down_digit #(.MAX(MIN_UNITS_MAX)) u_min_units (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_en),
      .load     (load_en),
      .load_val (data_min_units),
      .dec      (dec_en),
      .step     (st_wrap),
      .digit    (min_units),
      .wrap     (mu_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         beep_cnt     <= 4'd0;
         pgt_d        <= 1'b0;
         magnetron_on <= 1'b0;
         done_beep    <= 1'b0;
      end else begin
         state        <= state_n;
         beep_cnt     <= beep_n;
         pgt_d        <= pgt_1Hz;
         magnetron_on <= (state_n == RUNNING);
         done_beep    <= (state_n == DONE);
      end
   end

   // Priority inside each state: clear > door open > stop > start > tick.
   always_comb begin
      state_n = state;
      beep_n  = beep_cnt;
      load_en = 1'b0;
      clr_en  = 1'b0;
      dec_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear)
               clr_en = 1'b1;
            else if (!loadn)
               load_en = 1'b1;
            else if (start && door_closed && !zero)
               state_n = RUNNING;
         end
         RUNNING: begin
            if (clear) begin
               clr_en  = 1'b1;
               state_n = IDLE;
            end else if (!door_closed || stop) begin
               state_n = PAUSED;
            end else if (tick && !zero) begin
               dec_en = 1'b1;
               if (last) begin
                  state_n = DONE;
                  beep_n  = 4'd0;
               end
            end
         end
         PAUSED: begin
            if (clear) begin
               clr_en  = 1'b1;
               state_n = IDLE;
            end else if (door_closed && !stop && start) begin
               state_n = RUNNING;
            end
         end
         DONE: begin
            if (clear) begin
               clr_en  = 1'b1;
               state_n = IDLE;
            end else if (!loadn) begin
               load_en = 1'b1;
               state_n = IDLE;
            end else if (tick) begin
               beep_n = beep_cnt + 4'd1;
               if (beep_n >= HOLD)
                  state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   logic unused;
   assign unused = mu_wrap;

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Scoreboard bench for the microwave countdown timer.
module tb_microwave_countdown_timer;

   logic       clk = 1'b0;
   logic       rst, pgt, loadn, start, stop, clear, door;
   logic [3:0] dsu, dst, dmu;
   logic [3:0] su, st, mu;
   logic       zero, mag, beep;

   int checks = 0;
   int errors = 0;
   logic [14:0] sb[$];

   always #5 clk = ~clk;

   microwave_countdown_timer #(.DONE_HOLD_TICKS(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .pgt_1Hz        (pgt),
      .loadn          (loadn),
      .data_sec_units (dsu),
      .data_sec_tens  (dst),
      .data_min_units (dmu),
      .start          (start),
      .stop           (stop),
      .clear          (clear),
      .door_closed    (door),
      .sec_units      (su),
      .sec_tens       (st),
      .min_units      (mu),
      .zero           (zero),
      .magnetron_on   (mag),
      .done_beep      (beep)
   );

   wire [14:0] obs = {mu, st, su, zero, mag, beep};

   function automatic logic [14:0] ev(int m, int t, int u, bit mg, bit bp);
      logic z;
      z = (m == 0) && (t == 0) && (u == 0);
      return {m[3:0], t[3:0], u[3:0], z, mg, bp};
   endfunction

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic load(int m, int t, int u);
      loadn = 1'b0;
      dmu = m[3:0]; dst = t[3:0]; dsu = u[3:0];
      step(1);
      loadn = 1'b1;
   endtask

   task automatic pulse();
      pgt = 1'b1;
      step(1);
      pgt = 1'b0;
      step(1);
   endtask

   task automatic go();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [14:0] e;
      rst = 1'b1;
      sb.push_back(ev(0, 0, 0, 0, 0));
      step(1);
      rst = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset: got %h want %h", obs, e);
      end
   endtask

   task automatic test_load_count();
      logic [14:0] e;
      load(0, 0, 5);
      sb.push_back(ev(0, 0, 5, 0, 0));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL load_0_05: got %h want %h", obs, e);
      end
      go();
      sb.push_back(ev(0, 0, 5, 1, 0));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL start: got %h want %h", obs, e);
      end
      for (int i = 4; i >= 0; i--) begin
         pgt = 1'b1;
         sb.push_back(ev(0, 0, i, i != 0, i == 0));
         step(1);
         e = sb.pop_front(); checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL count_%0d: got %h want %h", i, obs, e);
         end
         pgt = 1'b0;
         step(1);
      end
      for (int k = 0; k < 3; k++) begin
         sb.push_back(ev(0, 0, 0, 0, k < 2));
         pulse();
         e = sb.pop_front(); checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL beep_hold_%0d: got %h want %h", k, obs, e);
         end
      end
   endtask

   task automatic test_borrow();
      logic [14:0] e;
      load(1, 0, 0);
      go();
      sb.push_back(ev(0, 5, 9, 1, 0));
      pulse();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL borrow_059: got %h want %h", obs, e);
      end
      repeat (58) pulse();
      sb.push_back(ev(0, 0, 1, 1, 0));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL borrow_001: got %h want %h", obs, e);
      end
      sb.push_back(ev(0, 0, 0, 0, 1));
      pulse();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL borrow_done: got %h want %h", obs, e);
      end
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic test_door();
      logic [14:0] e;
      load(0, 3, 0);
      go();
      door = 1'b0;
      pgt = 1'b1;
      sb.push_back(ev(0, 3, 0, 0, 0));
      step(1);
      pgt = 1'b0;
      step(1);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL door_pause: got %h want %h", obs, e);
      end
      door = 1'b1;
      sb.push_back(ev(0, 3, 0, 0, 0));
      pulse();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL paused_tick: got %h want %h", obs, e);
      end
      go();
      sb.push_back(ev(0, 2, 9, 1, 0));
      pulse();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL resume: got %h want %h", obs, e);
      end
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic test_clamp();
      logic [14:0] e;
      load(0, 7, 12);
      sb.push_back(ev(0, 5, 9, 0, 0));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL clamp: got %h want %h", obs, e);
      end
      load(15, 0, 0);
      sb.push_back(ev(9, 0, 0, 0, 0));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL clamp_min: got %h want %h", obs, e);
      end
      load(0, 0, 0);
      go();
      sb.push_back(ev(0, 0, 0, 0, 0));
      pulse();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL zero_start: got %h want %h", obs, e);
      end
   endtask

   task automatic test_clear_reset();
      logic [14:0] e;
      load(2, 1, 5);
      go();
      pulse();
      clear = 1'b1;
      sb.push_back(ev(0, 0, 0, 0, 0));
      step(1);
      clear = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL clear: got %h want %h", obs, e);
      end
      load(2, 1, 5);
      go();
      load(5, 5, 5);
      sb.push_back(ev(2, 1, 4, 1, 0));
      pulse();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL load_ignored: got %h want %h", obs, e);
      end
      rst = 1'b1;
      sb.push_back(ev(0, 0, 0, 0, 0));
      step(1);
      rst = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_mid: got %h want %h", obs, e);
      end
   endtask

   task automatic test_held_tick();
      logic [14:0] e;
      load(0, 1, 0);
      go();
      pgt = 1'b1;
      sb.push_back(ev(0, 0, 9, 1, 0));
      step(1);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL held_first: got %h want %h", obs, e);
      end
      sb.push_back(ev(0, 0, 9, 1, 0));
      step(9);
      pgt = 1'b0;
      step(1);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL held_level: got %h want %h", obs, e);
      end
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [14:0] e;
      load(0, 0, 1);
      go();
      sb.push_back(ev(0, 0, 0, 0, 1));
      pulse();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL b2b_done: got %h want %h", obs, e);
      end
      load(0, 0, 3);
      sb.push_back(ev(0, 0, 3, 0, 0));
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL b2b_reload: got %h want %h", obs, e);
      end
      go();
      sb.push_back(ev(0, 0, 2, 1, 0));
      pulse();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL b2b_run: got %h want %h", obs, e);
      end
      stop = 1'b1;
      start = 1'b1;
      sb.push_back(ev(0, 0, 2, 0, 0));
      pulse();
      stop = 1'b0;
      start = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL stop_prio: got %h want %h", obs, e);
      end
   endtask

   initial begin
      rst = 1'b1; pgt = 1'b0; loadn = 1'b1;
      start = 1'b0; stop = 1'b0; clear = 1'b0; door = 1'b1;
      dsu = 4'd0; dst = 4'd0; dmu = 4'd0;
      @(negedge clk);
      test_reset();
      test_load_count();
      test_borrow();
      test_door();
      test_clamp();
      test_clear_reset();
      test_held_tick();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
